uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the UART receive FIFO. It turns host register strobes into FIFO pop, flush and status-clear pulses. It also tracks FIFO occupancy against the programmed trigger level and runs the 16550 character-timeout counter. It sits between the register block and the receive FIFO, and produces the receive-related interrupt sources, the LSR data-ready bit and the interrupt ID.

## Interface
- FIFO_DEPTH, 16, entries in the receive FIFO; trigger levels are 1, 4, 8 and 14 for depth 16.
- FIFO_COUNTER_W, 5, width of the FIFO occupancy count.
- TO_W, 10, width of the timeout counter; must hold 12*64 = 768.
- clk  in  1  single clock.
- nreset  in  1  asynchronous, active-low reset.
- tick  in  1  16x baud enable, one cycle wide.
- lcr  in  4  line control register: [1:0] data bits minus 5, [2] two stop bits, [3] parity enable.
- fcr_wr  in  1  FCR write strobe.
- fcr_rxrst  in  1  RX FIFO reset bit, qualified by fcr_wr.
- fcr_trig  in  2  trigger select, latched on fcr_wr: 00=1, 01=4, 10=8, 11=14.
- ier_rda  in  1  enable for the receive-data and timeout interrupts.
- ier_rls  in  1  enable for the line-status interrupt.
- rbr_rd  in  1  RBR read strobe.
- lsr_rd  in  1  LSR read strobe.
- rx_push  in  1  receiver push into the FIFO.
- count  in  FIFO_COUNTER_W  FIFO occupancy.
- overrun  in  1  FIFO overrun flag.
- error_bit  in  1  FIFO-wide parity/framing/break error flag.
- pop  out  1  FIFO pop pulse.
- fifo_reset  out  1  FIFO flush pulse.
- reset_status  out  1  overrun-clear pulse.
- data_ready  out  1  LSR bit 0.
- lsr_err  out  1  LSR bit 7.
- irq  out  1  interrupt request.
- iid  out  4  interrupt ID.

## Operation
- FSM states are IDLE, POP, FLUSH and SETTLE; reset state is IDLE.
  - IDLE, fcr_wr&fcr_rxrst: go to FLUSH. This has priority over rbr_rd in the same cycle.
  - IDLE, rbr_rd with eff_count>0: go to POP.
  - POP: pop=1 for one cycle. Go to IDLE, or to FLUSH if fcr_wr&fcr_rxrst arrives.
  - FLUSH: fifo_reset=1 for one cycle, then go to SETTLE.
  - SETTLE: one cycle; rbr_rd is ignored and all pending flags are held clear. Then go to IDLE.
- eff_count = count - pop, so a back-to-back rbr_rd is judged on the post-pop count.
  - rbr_rd in POP with eff_count>0 re-enters POP, so pop stays high the next cycle.
  - rbr_rd with eff_count==0 is dropped.
- Trigger level trig_lvl: 2-bit register, reset 00, loaded from fcr_trig on every fcr_wr.
  - rda_pend = (eff_count >= level), combinational, forced 0 in FLUSH/SETTLE.
- Character bits: cbits = 1 + (5+lcr[1:0]) + lcr[3] + (lcr[2]?2:1), range 7..12.
  - Timeout reload value = cbits*64, i.e. 4 characters in 16x ticks.
- Timeout counter:
  - Reload when any of rx_push, pop or count==0.
  - Otherwise decrement on tick while nonzero.
  - ti_pend sets when the counter reaches 0 with count>0.
  - ti_pend clears on pop, rx_push, fifo_reset or count==0.
- Line-status pending flag rls_pend:
  - Sets on a rising edge of overrun or of error_bit; edge detect uses a registered copy, reset 0.
  - Clears on lsr_rd or fifo_reset.
  - Set wins over clear in the same cycle.
- lsr_rd produces reset_status=1 in the next cycle, for one cycle.
- data_ready = (count != 0); it is 0 in FLUSH/SETTLE.
- lsr_err = error_bit.
- Interrupt priority:
  - rls_pend&ier_rls: iid=0110.
  - else rda_pend&ier_rda: iid=0100.
  - else ti_pend&ier_rda: iid=1100.
  - else iid=0001.
  - irq = ~iid[0].

## Timing
- Reset values: pop, fifo_reset, reset_status, irq, data_ready and lsr_err all 0; iid=0001; timeout counter=768; trig_lvl=00.
- rbr_rd in cycle N gives pop in N+1 and count decrement at the end of N+1. The host samples FIFO data in cycle N.
- fcr_wr with fcr_rxrst in N gives fifo_reset in N+1 and SETTLE in N+2. rbr_rd is accepted again from N+3.
- All outputs are registered except iid, irq, data_ready and lsr_err, which are combinational from registered state and inputs.
- nreset asserted mid-POP or mid-FLUSH aborts immediately. No pulse is emitted after release.
- An lcr change takes effect at the next reload.

## Test plan
- Reset: all outputs at reset values; iid=0001.
- Push 3 characters with trig_lvl=01 → no RDA interrupt. A 4th rx_push → iid=0100 the next cycle. Two back-to-back rbr_rd → two pop cycles; iid returns to 0001 after count reaches 3.
- One character, lcr=0011 (cbits=10): after 640 ticks with no push or pop → iid=1100. rbr_rd → pop; ti_pend clears; iid=0001.
- Overrun rises while ier_rls=1 → iid=0110, overriding a pending RDA. lsr_rd → reset_status pulse the next cycle; iid falls to 0100.
- fcr_wr with fcr_rxrst in the same cycle as rbr_rd → fifo_reset pulse with no pop. rbr_rd during SETTLE is ignored. data_ready=0 through SETTLE.
- rbr_rd with count=0 → no pop. rbr_rd repeated in POP with count=1 → exactly one pop.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receive FIFO.
// Turns host register strobes into FIFO pop/flush/status-clear pulses, tracks
// occupancy against the programmed trigger level, runs the character-timeout
// counter and resolves the receive-related interrupt sources into irq/iid.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_COUNTER_W = 5,
    parameter int TO_W           = 10
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      tick,
    input  logic [3:0]                lcr,
    input  logic                      fcr_wr,
    input  logic                      fcr_rxrst,
    input  logic [1:0]                fcr_trig,
    input  logic                      ier_rda,
    input  logic                      ier_rls,
    input  logic                      rbr_rd,
    input  logic                      lsr_rd,
    input  logic                      rx_push,
    input  logic [FIFO_COUNTER_W-1:0] count,
    input  logic                      overrun,
    input  logic                      error_bit,
    output logic                      pop,
    output logic                      fifo_reset,
    output logic                      reset_status,
    output logic                      data_ready,
    output logic                      lsr_err,
    output logic                      irq,
    output logic [3:0]                iid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        FLUSH  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]                trig_lvl;
    logic [FIFO_COUNTER_W-1:0] trig_level;
    logic [FIFO_COUNTER_W-1:0] eff_count;
    logic                      flush_req;
    logic                      pop_ok;
    logic                      in_flush;
    logic                      count_zero;

    logic [3:0]                cbits;
    logic [TO_W-1:0]           to_reload;
    logic [TO_W-1:0]           to_cnt;
    logic [TO_W-1:0]           to_next;
    logic                      ti_pend;
    logic                      ti_clear;

    logic                      rda_pend;
    logic                      rls_pend;
    logic                      overrun_q;
    logic                      error_q;
    logic                      status_rise;

    // Occupancy as it will be once an in-flight pop lands, so back-to-back
    // reads and the trigger comparison both see the post-pop count.
    assign eff_count  = count - FIFO_COUNTER_W'(pop);
    assign count_zero = (count == '0);
    assign flush_req  = fcr_wr & fcr_rxrst;
    assign pop_ok     = rbr_rd & (eff_count != '0);
    assign in_flush   = (state == FLUSH) || (state == SETTLE);

    // Character length in bits including start, parity and stop bits (7..12);
    // four characters at 16 ticks per bit is cbits*64 ticks.
    assign cbits     = 4'd6 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + (lcr[2] ? 4'd2 : 4'd1);
    assign to_reload = TO_W'({cbits, 6'b000000});

    // State register; reset drops any in-flight pop or flush immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an RX FIFO reset outranks a simultaneous RBR read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush_req)   state_next = FLUSH;
                else if (pop_ok) state_next = POP;
            end
            POP: begin
                if (flush_req)   state_next = FLUSH;
                else if (pop_ok) state_next = POP;
                else             state_next = IDLE;
            end
            FLUSH:   state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pulse outputs decoded directly from the state register.
    always_comb begin
        pop        = 1'b0;
        fifo_reset = 1'b0;
        case (state)
            POP:     pop        = 1'b1;
            FLUSH:   fifo_reset = 1'b1;
            default: ;
        endcase
    end

    // Trigger select is captured on every FCR write, flush or not.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            trig_lvl <= 2'b00;
        end else if (fcr_wr) begin
            trig_lvl <= fcr_trig;
        end
    end

    // Map the trigger select onto an occupancy threshold (1/4/8/14 at depth 16).
    always_comb begin
        trig_level = FIFO_COUNTER_W'(1);
        case (trig_lvl)
            2'b00: trig_level = FIFO_COUNTER_W'(1);
            2'b01: trig_level = FIFO_COUNTER_W'(FIFO_DEPTH / 4);
            2'b10: trig_level = FIFO_COUNTER_W'(FIFO_DEPTH / 2);
            2'b11: trig_level = FIFO_COUNTER_W'(FIFO_DEPTH - 2);
            default: ;
        endcase
    end

    assign rda_pend = (eff_count >= trig_level) && !in_flush;

    // Next timeout count: any FIFO activity or an empty FIFO restarts the window.
    always_comb begin
        to_next = to_cnt;
        if (rx_push || pop || count_zero) begin
            to_next = to_reload;
        end else if (tick && (to_cnt != '0)) begin
            to_next = to_cnt - TO_W'(1);
        end
    end

    assign ti_clear = pop | rx_push | fifo_reset | count_zero | (state == SETTLE);

    // Timeout counter and its pending flag; the flag rises on the same edge the
    // counter lands on zero while data is still waiting.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            to_cnt  <= TO_W'(12 * 64);
            ti_pend <= 1'b0;
        end else begin
            to_cnt <= to_next;
            if (ti_clear) begin
                ti_pend <= 1'b0;
            end else if (to_next == '0) begin
                ti_pend <= 1'b1;
            end
        end
    end

    assign status_rise = (overrun & ~overrun_q) | (error_bit & ~error_q);

    // Line-status pending flag; a new error edge beats a same-cycle LSR read.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overrun_q    <= 1'b0;
            error_q      <= 1'b0;
            rls_pend     <= 1'b0;
            reset_status <= 1'b0;
        end else begin
            overrun_q    <= overrun;
            error_q      <= error_bit;
            reset_status <= lsr_rd;
            if (state == SETTLE) begin
                rls_pend <= 1'b0;
            end else if (status_rise) begin
                rls_pend <= 1'b1;
            end else if (lsr_rd || fifo_reset) begin
                rls_pend <= 1'b0;
            end
        end
    end

    // Interrupt priority: line status, then received data, then timeout.
    always_comb begin
        iid = 4'b0001;
        if (rls_pend && ier_rls) begin
            iid = 4'b0110;
        end else if (rda_pend && ier_rda) begin
            iid = 4'b0100;
        end else if (ti_pend && ier_rda) begin
            iid = 4'b1100;
        end
    end

    assign irq        = ~iid[0];
    assign data_ready = !count_zero && !in_flush;
    assign lsr_err    = error_bit;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl.
// The bench plays the receive FIFO: it keeps the occupancy count, growing it
// on rx_push, shrinking it when the controller pops and emptying it on flush.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       nreset;
    logic       tick;
    logic [3:0] lcr;
    logic       fcr_wr;
    logic       fcr_rxrst;
    logic [1:0] fcr_trig;
    logic       ier_rda;
    logic       ier_rls;
    logic       rbr_rd;
    logic       lsr_rd;
    logic       rx_push;
    logic [4:0] count;
    logic       overrun;
    logic       error_bit;
    logic       pop;
    logic       fifo_reset;
    logic       reset_status;
    logic       data_ready;
    logic       lsr_err;
    logic       irq;
    logic [3:0] iid;

    int n_cmp;
    int n_fail;

    uart_rx_ctrl #(
        .FIFO_DEPTH(16),
        .FIFO_COUNTER_W(5),
        .TO_W(10)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .tick(tick),
        .lcr(lcr),
        .fcr_wr(fcr_wr),
        .fcr_rxrst(fcr_rxrst),
        .fcr_trig(fcr_trig),
        .ier_rda(ier_rda),
        .ier_rls(ier_rls),
        .rbr_rd(rbr_rd),
        .lsr_rd(lsr_rd),
        .rx_push(rx_push),
        .count(count),
        .overrun(overrun),
        .error_bit(error_bit),
        .pop(pop),
        .fifo_reset(fifo_reset),
        .reset_status(reset_status),
        .data_ready(data_ready),
        .lsr_err(lsr_err),
        .irq(irq),
        .iid(iid)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and update the FIFO occupancy the way a real FIFO
    // would; a push in the flush cycle lands after the flush.
    task automatic step();
        logic pb;
        logic pu;
        logic fb;
        pb = pop;
        pu = rx_push;
        fb = fifo_reset;
        @(posedge clk);
        #1;
        if (fb) count = pu ? 5'd1 : 5'd0;
        else    count = count + 5'(pu) - 5'(pb);
        #1;
    endtask

    // Hold reset for two clocks with all inputs idle, then release.
    task automatic do_reset();
        nreset    = 1'b0;
        tick      = 1'b0;
        lcr       = 4'b0000;
        fcr_wr    = 1'b0;
        fcr_rxrst = 1'b0;
        fcr_trig  = 2'b00;
        ier_rda   = 1'b1;
        ier_rls   = 1'b1;
        rbr_rd    = 1'b0;
        lsr_rd    = 1'b0;
        rx_push   = 1'b0;
        count     = 5'd0;
        overrun   = 1'b0;
        error_bit = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nreset = 1'b1;
        #1;
    endtask

    task automatic push_one();
        rx_push = 1'b1;
        step();
        rx_push = 1'b0;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        nreset = 1'b0;
        #1;
        n_cmp++; if (pop !== 1'b0)          begin n_fail++; $display("[TB] FAIL reset_pop: got %b want 0", pop); end
        n_cmp++; if (fifo_reset !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_fifo_reset: got %b want 0", fifo_reset); end
        n_cmp++; if (reset_status !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_status: got %b want 0", reset_status); end
        n_cmp++; if (data_ready !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_data_ready: got %b want 0", data_ready); end
        n_cmp++; if (lsr_err !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_lsr_err: got %b want 0", lsr_err); end
        n_cmp++; if (irq !== 1'b0)          begin n_fail++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (iid !== 4'b0001)       begin n_fail++; $display("[TB] FAIL reset_iid: got %b want 0001", iid); end
    endtask

    // Trigger level 4: three characters stay quiet, the fourth raises RDA,
    // and two back-to-back reads pop twice.
    task automatic test_rda_trigger();
        do_reset();
        fcr_wr   = 1'b1;
        fcr_trig = 2'b01;
        step();
        fcr_wr   = 1'b0;
        repeat (3) push_one();
        n_cmp++; if (iid !== 4'b0001)     begin n_fail++; $display("[TB] FAIL rda_below_trig_iid: got %b want 0001", iid); end
        n_cmp++; if (data_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rda_data_ready: got %b want 1", data_ready); end
        push_one();
        n_cmp++; if (iid !== 4'b0100)     begin n_fail++; $display("[TB] FAIL rda_at_trig_iid: got %b want 0100", iid); end
        n_cmp++; if (irq !== 1'b1)        begin n_fail++; $display("[TB] FAIL rda_irq: got %b want 1", irq); end
        rbr_rd = 1'b1;
        step();
        n_cmp++; if (pop !== 1'b1)        begin n_fail++; $display("[TB] FAIL rda_pop1: got %b want 1", pop); end
        n_cmp++; if (iid !== 4'b0001)     begin n_fail++; $display("[TB] FAIL rda_iid_post_pop: got %b want 0001", iid); end
        step();
        n_cmp++; if (pop !== 1'b1)        begin n_fail++; $display("[TB] FAIL rda_pop2: got %b want 1", pop); end
        n_cmp++; if (count !== 5'd3)      begin n_fail++; $display("[TB] FAIL rda_count_mid: got %0d want 3", count); end
        rbr_rd = 1'b0;
        step();
        n_cmp++; if (pop !== 1'b0)        begin n_fail++; $display("[TB] FAIL rda_pop_end: got %b want 0", pop); end
        n_cmp++; if (count !== 5'd2)      begin n_fail++; $display("[TB] FAIL rda_count_end: got %0d want 2", count); end
        n_cmp++; if (iid !== 4'b0001)     begin n_fail++; $display("[TB] FAIL rda_iid_end: got %b want 0001", iid); end
    endtask

    // lcr=0011 gives 10-bit characters, so the timeout fires after 640 ticks.
    task automatic test_timeout();
        do_reset();
        lcr      = 4'b0011;
        fcr_wr   = 1'b1;
        fcr_trig = 2'b11;
        step();
        fcr_wr   = 1'b0;
        push_one();
        tick = 1'b1;
        repeat (639) step();
        n_cmp++; if (iid !== 4'b0001) begin n_fail++; $display("[TB] FAIL to_before_expiry_iid: got %b want 0001", iid); end
        step();
        tick = 1'b0;
        n_cmp++; if (iid !== 4'b1100) begin n_fail++; $display("[TB] FAIL to_expired_iid: got %b want 1100", iid); end
        n_cmp++; if (irq !== 1'b1)    begin n_fail++; $display("[TB] FAIL to_expired_irq: got %b want 1", irq); end
        rbr_rd = 1'b1;
        step();
        rbr_rd = 1'b0;
        n_cmp++; if (pop !== 1'b1)    begin n_fail++; $display("[TB] FAIL to_pop: got %b want 1", pop); end
        step();
        n_cmp++; if (iid !== 4'b0001) begin n_fail++; $display("[TB] FAIL to_cleared_iid: got %b want 0001", iid); end
        n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL to_data_ready: got %b want 0", data_ready); end
    endtask

    // Line status outranks RDA; an LSR read clears it and pulses reset_status.
    task automatic test_line_status();
        do_reset();
        push_one();
        n_cmp++; if (iid !== 4'b0100)        begin n_fail++; $display("[TB] FAIL rls_pre_iid: got %b want 0100", iid); end
        overrun = 1'b1;
        step();
        n_cmp++; if (iid !== 4'b0110)        begin n_fail++; $display("[TB] FAIL rls_overrun_iid: got %b want 0110", iid); end
        lsr_rd = 1'b1;
        step();
        lsr_rd = 1'b0;
        n_cmp++; if (reset_status !== 1'b1)  begin n_fail++; $display("[TB] FAIL rls_reset_status: got %b want 1", reset_status); end
        n_cmp++; if (iid !== 4'b0100)        begin n_fail++; $display("[TB] FAIL rls_after_read_iid: got %b want 0100", iid); end
        step();
        n_cmp++; if (reset_status !== 1'b0)  begin n_fail++; $display("[TB] FAIL rls_reset_status_end: got %b want 0", reset_status); end
        error_bit = 1'b1;
        #1;
        n_cmp++; if (lsr_err !== 1'b1)       begin n_fail++; $display("[TB] FAIL rls_lsr_err: got %b want 1", lsr_err); end
        step();
        n_cmp++; if (iid !== 4'b0110)        begin n_fail++; $display("[TB] FAIL rls_error_iid: got %b want 0110", iid); end
        ier_rls = 1'b0;
        #1;
        n_cmp++; if (iid !== 4'b0100)        begin n_fail++; $display("[TB] FAIL rls_masked_iid: got %b want 0100", iid); end
    endtask

    // Flush beats a simultaneous read; reads are ignored until SETTLE ends.
    task automatic test_flush();
        do_reset();
        push_one();
        push_one();
        fcr_wr    = 1'b1;
        fcr_rxrst = 1'b1;
        rbr_rd    = 1'b1;
        step();
        fcr_wr    = 1'b0;
        fcr_rxrst = 1'b0;
        n_cmp++; if (fifo_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_fifo_reset: got %b want 1", fifo_reset); end
        n_cmp++; if (pop !== 1'b0)        begin n_fail++; $display("[TB] FAIL fl_no_pop: got %b want 0", pop); end
        n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_data_ready: got %b want 0", data_ready); end
        rx_push = 1'b1;
        step();
        rx_push = 1'b0;
        n_cmp++; if (fifo_reset !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_settle_fifo_reset: got %b want 0", fifo_reset); end
        n_cmp++; if (pop !== 1'b0)        begin n_fail++; $display("[TB] FAIL fl_settle_pop: got %b want 0", pop); end
        n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_settle_data_ready: got %b want 0", data_ready); end
        n_cmp++; if (iid !== 4'b0001)     begin n_fail++; $display("[TB] FAIL fl_settle_iid: got %b want 0001", iid); end
        step();
        n_cmp++; if (pop !== 1'b0)        begin n_fail++; $display("[TB] FAIL fl_settle_read_ignored: got %b want 0", pop); end
        n_cmp++; if (data_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_idle_data_ready: got %b want 1", data_ready); end
        n_cmp++; if (iid !== 4'b0100)     begin n_fail++; $display("[TB] FAIL fl_idle_iid: got %b want 0100", iid); end
        step();
        rbr_rd = 1'b0;
        n_cmp++; if (pop !== 1'b1)        begin n_fail++; $display("[TB] FAIL fl_read_accepted: got %b want 1", pop); end
        step();
        n_cmp++; if (count !== 5'd0)      begin n_fail++; $display("[TB] FAIL fl_final_count: got %0d want 0", count); end
    endtask

    // Reads against an empty FIFO are dropped; a held read on one entry pops once.
    task automatic test_empty_reads();
        int pops;
        do_reset();
        rbr_rd = 1'b1;
        step();
        rbr_rd = 1'b0;
        n_cmp++; if (pop !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_no_pop: got %b want 0", pop); end
        push_one();
        pops   = 0;
        rbr_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pop === 1'b1) pops++;
        end
        rbr_rd = 1'b0;
        n_cmp++; if (pops !== 1)     begin n_fail++; $display("[TB] FAIL single_pop_count: got %0d want 1", pops); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL single_pop_final_count: got %0d want 0", count); end
    endtask

    // Reset asserted mid-POP or mid-FLUSH kills the pulse at once.
    task automatic test_back_to_back_abort();
        do_reset();
        push_one();
        rbr_rd = 1'b1;
        step();
        rbr_rd = 1'b0;
        n_cmp++; if (pop !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_pop_started: got %b want 1", pop); end
        nreset = 1'b0;
        #1;
        n_cmp++; if (pop !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_pop_killed: got %b want 0", pop); end
        nreset = 1'b1;
        step();
        n_cmp++; if (pop !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_pop_after_release: got %b want 0", pop); end
        fcr_wr    = 1'b1;
        fcr_rxrst = 1'b1;
        step();
        fcr_wr    = 1'b0;
        fcr_rxrst = 1'b0;
        n_cmp++; if (fifo_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_flush_started: got %b want 1", fifo_reset); end
        nreset = 1'b0;
        #1;
        n_cmp++; if (fifo_reset !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flush_killed: got %b want 0", fifo_reset); end
        count  = 5'd1;
        nreset = 1'b1;
        step();
        n_cmp++; if (fifo_reset !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flush_after_release: got %b want 0", fifo_reset); end
        n_cmp++; if (data_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_data_ready: got %b want 1", data_ready); end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        do_reset();
        test_reset();
        test_rda_trigger();
        test_timeout();
        test_line_status();
        test_flush();
        test_empty_reads();
        test_back_to_back_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
